// File: rtl/sum_bcd_display_pkg.sv
// Shared definitions for the sum_bcd_display block: FSM encoding, widths,
// segment constants and the double-dabble nibble correction helper.
package sum_bcd_display_pkg;

  localparam int unsigned BIN_W       = 9;
  localparam int unsigned DIGITS      = 3;
  localparam int unsigned BCD_W       = 4 * DIGITS;
  localparam int unsigned SR_W        = BCD_W + BIN_W;
  localparam int unsigned SHIFT_COUNT = 9;
  localparam int unsigned CNT_W       = 4;

  // FSM encoding
  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ADJUST = 2'd1;
  localparam logic [1:0] ST_SHIFT  = 2'd2;
  localparam logic [1:0] ST_DONE   = 2'd3;

  // Active-low segments {g,f,e,d,c,b,a}
  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_ZERO  = 7'b1000000;

  typedef struct packed {
    logic [3:0] hundreds;
    logic [3:0] tens;
    logic [3:0] units;
  } bcd_digits_t;

  // Double-dabble correction: a nibble of 5 or more would overflow past 9
  // after the next doubling, so pre-add 3.
  function automatic logic [3:0] add3_if_ge5(input logic [3:0] d);
    return (d >= 4'd5) ? (d + 4'd3) : d;
  endfunction

endpackage

// File: rtl/bcd_to_seg7.sv
// BCD digit to active-low seven-segment decoder {g,f,e,d,c,b,a}.
// Non-decimal codes turn every segment off.
module bcd_to_seg7
  import sum_bcd_display_pkg::*;
(
  input  logic [3:0] i_bcd,
  output logic [6:0] o_seg
);

  // Pure lookup, no state
  always_comb begin
    o_seg = SEG_BLANK;
    case (i_bcd)
      4'd0:    o_seg = SEG_ZERO;
      4'd1:    o_seg = 7'b1111001;
      4'd2:    o_seg = 7'b0100100;
      4'd3:    o_seg = 7'b0110000;
      4'd4:    o_seg = 7'b0011001;
      4'd5:    o_seg = 7'b0010010;
      4'd6:    o_seg = 7'b0000010;
      4'd7:    o_seg = 7'b1111000;
      4'd8:    o_seg = 7'b0000000;
      4'd9:    o_seg = 7'b0010000;
      default: o_seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/sum_bcd_display.sv
// Converts the adder result {cout,S} (0..510) into three BCD digits with a
// sequential shift-and-add-3 engine and holds them for the displays.
// Optional seven-segment outputs are built when SEVEN_SEG_EN is defined.
module sum_bcd_display
  import sum_bcd_display_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       cout,
  input  logic [7:0] S,
  output logic       busy,
  output logic       done,
  output logic [3:0] hundreds,
  output logic [3:0] tens,
  output logic [3:0] units
`ifdef SEVEN_SEG_EN
  ,
  output logic [6:0] hex2,
  output logic [6:0] hex1,
  output logic [6:0] hex0
`endif
);

  logic [1:0]      r_state;
  logic [SR_W-1:0] r_shift;
  logic [CNT_W-1:0] r_count;
  logic            r_busy;
  logic            r_done;
  bcd_digits_t     r_digits;

  logic [1:0]      w_state_d;
  logic [SR_W-1:0] w_shift_d;
  logic [CNT_W-1:0] w_count_d;
  logic            w_done_d;
  bcd_digits_t     w_digits_d;

  // Next-state logic for the conversion engine
  always_comb begin
    w_state_d  = r_state;
    w_shift_d  = r_shift;
    w_count_d  = r_count;
    w_digits_d = r_digits;
    w_done_d   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_shift_d = {{BCD_W{1'b0}}, cout, S};
          w_count_d = CNT_W'(SHIFT_COUNT);
          w_state_d = ST_ADJUST;
        end
      end
      ST_ADJUST: begin
        w_shift_d[20:17] = add3_if_ge5(r_shift[20:17]);
        w_shift_d[16:13] = add3_if_ge5(r_shift[16:13]);
        w_shift_d[12:9]  = add3_if_ge5(r_shift[12:9]);
        w_state_d        = ST_SHIFT;
      end
      ST_SHIFT: begin
        w_shift_d = {r_shift[SR_W-2:0], 1'b0};
        w_count_d = r_count - 1'b1;
        w_state_d = (w_count_d == '0) ? ST_DONE : ST_ADJUST;
      end
      ST_DONE: begin
        w_digits_d = bcd_digits_t'(r_shift[SR_W-1:BIN_W]);
        w_done_d   = 1'b1;
        w_state_d  = ST_IDLE;
      end
      default: begin
        w_state_d = ST_IDLE;
      end
    endcase
  end

  // State, datapath and output registers; busy is registered alongside state
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state  <= ST_IDLE;
      r_shift  <= '0;
      r_count  <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_digits <= '0;
    end else begin
      r_state  <= w_state_d;
      r_shift  <= w_shift_d;
      r_count  <= w_count_d;
      r_busy   <= (w_state_d != ST_IDLE);
      r_done   <= w_done_d;
      r_digits <= w_digits_d;
    end
  end

  assign busy     = r_busy;
  assign done     = r_done;
  assign hundreds = r_digits.hundreds;
  assign tens     = r_digits.tens;
  assign units    = r_digits.units;

`ifdef SEVEN_SEG_EN
  bcd_to_seg7 u_seg_hundreds (
    .i_bcd (r_digits.hundreds),
    .o_seg (hex2)
  );

  bcd_to_seg7 u_seg_tens (
    .i_bcd (r_digits.tens),
    .o_seg (hex1)
  );

  bcd_to_seg7 u_seg_units (
    .i_bcd (r_digits.units),
    .o_seg (hex0)
  );
`endif

endmodule
